// File: rtl/hiscore_pkg.sv
// Shared types and default widths for the high-score RAM transfer engine.
package hiscore_pkg;

  localparam int ADDR_W_DEF      = 12;
  localparam int LEN_W_DEF       = 12;
  localparam int RD_LAT_DEF      = 2;
  localparam int CHK_TIMEOUT_DEF = 255;

  typedef enum logic [3:0] {
    IDLE,
    CHK_WAIT,
    CHK_READ,
    CHK_CMP,
    WR_SYNC,
    WRITE,
    RD_ISSUE,
    RD_WAIT,
    RD_SEND,
    DONE
  } hs_state_e;

endpackage

// File: rtl/hiscore_xfer_engine_frame_tick.sv
// Frame tick from the vblank rising edge, plus a saturating frame counter.
module hs_frame_tick
  import hiscore_pkg::*;
#(
  parameter int LIMIT = CHK_TIMEOUT_DEF
) (
  input  logic clk_49m,
  input  logic reset,
  input  logic vblank,
  input  logic clr,
  input  logic inc,
  output logic tick,
  output logic ovf
);

  localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic             vblank_q;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      vblank_q <= 1'b0;
      count    <= '0;
    end else begin
      vblank_q <= vblank;
      if (clr)
        count <= '0;
      else if (inc && !ovf)
        count <= count + CNT_W'(1);
    end
  end

  assign tick = vblank & ~vblank_q;
  assign ovf  = (count == CNT_W'(LIMIT));

endmodule

// File: rtl/hiscore_xfer_engine.sv
// High-score RAM initiator: gated restore into work RAM and windowed save out of it.
// state    | meaning
// IDLE     | waiting for a start pulse
// CHK_WAIT | restore: waiting for a frame tick, or timing out
// CHK_READ | restore: check address driven, read latency running
// CHK_CMP  | restore: compare check byte
// WR_SYNC  | restore: CPU paused, waiting for a frame tick
// WRITE    | restore: accepting bytes and writing them
// RD_ISSUE | save: drive window address
// RD_WAIT  | save: read latency running, then capture byte
// RD_SEND  | save: offering byte until accepted
// DONE     | completion pulse, release pause
module hiscore_xfer_engine
  import hiscore_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int LEN_W       = LEN_W_DEF,
  parameter int RD_LAT      = RD_LAT_DEF,
  parameter int CHK_TIMEOUT = CHK_TIMEOUT_DEF
) (
  input  logic              clk_49m,
  input  logic              reset,
  input  logic              vblank,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [ADDR_W-1:0] cfg_chk_addr,
  input  logic [7:0]        cfg_chk_val,
  input  logic              restore_start,
  input  logic              save_start,
  input  logic [7:0]        dl_data,
  input  logic              dl_valid,
  output logic              dl_ready,
  output logic [7:0]        ul_data,
  output logic              ul_valid,
  input  logic              ul_ready,
  output logic [ADDR_W-1:0] hs_address,
  output logic [7:0]        hs_data_in,
  input  logic [7:0]        hs_data_out,
  output logic              hs_write_enable,
  output logic              hs_access_write,
  output logic              pause_req,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int LAT_W = $clog2(RD_LAT + 1);

  hs_state_e         state, state_nxt;
  logic [ADDR_W-1:0] base_q, chk_addr_q, win_addr;
  logic [LEN_W-1:0]  len_q, idx, idx_inc;
  logic [7:0]        chk_val_q;
  logic [LAT_W-1:0]  lat_cnt;
  logic              tick, fc_ovf, fc_clr, fc_inc, accept, start_any;

  hs_frame_tick #(.LIMIT(CHK_TIMEOUT)) u_frame_tick (
    .clk_49m (clk_49m),
    .reset   (reset),
    .vblank  (vblank),
    .clr     (fc_clr),
    .inc     (fc_inc),
    .tick    (tick),
    .ovf     (fc_ovf)
  );

  assign win_addr  = base_q + ADDR_W'(idx);
  assign idx_inc   = idx + LEN_W'(1);
  assign start_any = (state == IDLE) && (save_start || restore_start);

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fc_clr    = 1'b0;
    fc_inc    = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (save_start) begin
          state_nxt = (cfg_len == '0) ? DONE : RD_ISSUE;
        end else if (restore_start) begin
          fc_clr    = 1'b1;
          state_nxt = (cfg_len == '0) ? DONE : CHK_WAIT;
        end
      end
      CHK_WAIT: begin
        if (fc_ovf)
          state_nxt = IDLE;
        else if (tick)
          state_nxt = CHK_READ;
      end
      CHK_READ: if (lat_cnt == '0) state_nxt = CHK_CMP;
      CHK_CMP: begin
        if (hs_data_out == chk_val_q) begin
          state_nxt = WR_SYNC;
        end else begin
          fc_inc    = 1'b1;
          state_nxt = CHK_WAIT;
        end
      end
      WR_SYNC: if (tick) state_nxt = WRITE;
      WRITE: begin
        if (idx == len_q)
          state_nxt = DONE;
        else
          accept = dl_valid & dl_ready;
      end
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  if (lat_cnt == '0) state_nxt = RD_SEND;
      RD_SEND:  if (ul_ready) state_nxt = (idx_inc == len_q) ? DONE : RD_ISSUE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Write strobe is registered, so dl_ready is held off while it is high.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      base_q          <= '0;
      chk_addr_q      <= '0;
      len_q           <= '0;
      chk_val_q       <= '0;
      idx             <= '0;
      lat_cnt         <= '0;
      hs_address      <= '0;
      hs_data_in      <= '0;
      hs_write_enable <= 1'b0;
      ul_data         <= '0;
    end else begin
      hs_write_enable <= accept;
      if (start_any) begin
        base_q     <= cfg_base;
        len_q      <= cfg_len;
        chk_addr_q <= cfg_chk_addr;
        chk_val_q  <= cfg_chk_val;
        idx        <= '0;
      end
      if (accept) begin
        hs_data_in <= dl_data;
        hs_address <= win_addr;
        idx        <= idx_inc;
      end
      case (state)
        CHK_WAIT: begin
          if (tick) begin
            hs_address <= chk_addr_q;
            lat_cnt    <= LAT_W'(RD_LAT - 1);
          end
        end
        CHK_READ, RD_WAIT: if (lat_cnt != '0) lat_cnt <= lat_cnt - LAT_W'(1);
        RD_ISSUE: begin
          hs_address <= win_addr;
          lat_cnt    <= LAT_W'(RD_LAT);
        end
        RD_SEND: if (ul_ready) idx <= idx_inc;
        default: ;
      endcase
      if (state == RD_WAIT && lat_cnt == '0)
        ul_data <= hs_data_out;
    end
  end

  assign busy            = (state != IDLE);
  assign done            = (state == DONE);
  assign error           = (state == CHK_WAIT) && fc_ovf;
  assign ul_valid        = (state == RD_SEND);
  assign hs_access_write = (state == WRITE);
  assign dl_ready        = (state == WRITE) && !hs_write_enable && (idx != len_q);
  assign pause_req       = (state == WR_SYNC) || (state == WRITE) || (state == RD_ISSUE) ||
                           (state == RD_WAIT) || (state == RD_SEND);

endmodule

// File: tb/tb_hiscore_xfer_engine.sv
// Directed bench for hiscore_xfer_engine against a latency-2 RAM model.
module tb_hiscore_xfer_engine;

  localparam int ADDR_W = 12;
  localparam int LEN_W  = 12;

  logic              clk_49m = 1'b0;
  logic              reset = 1'b1;
  logic              vblank = 1'b0;
  logic [ADDR_W-1:0] cfg_base = '0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic [ADDR_W-1:0] cfg_chk_addr = '0;
  logic [7:0]        cfg_chk_val = '0;
  logic              restore_start = 1'b0;
  logic              save_start = 1'b0;
  logic [7:0]        dl_data = '0;
  logic              dl_valid = 1'b0;
  logic              dl_ready;
  logic [7:0]        ul_data;
  logic              ul_valid;
  logic              ul_ready = 1'b0;
  logic [ADDR_W-1:0] hs_address;
  logic [7:0]        hs_data_in;
  logic [7:0]        hs_data_out;
  logic              hs_write_enable;
  logic              hs_access_write;
  logic              pause_req;
  logic              busy;
  logic              done;
  logic              error;

  hiscore_xfer_engine #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .RD_LAT(2), .CHK_TIMEOUT(3)
  ) dut (
    .clk_49m(clk_49m), .reset(reset), .vblank(vblank),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_chk_addr(cfg_chk_addr),
    .cfg_chk_val(cfg_chk_val), .restore_start(restore_start), .save_start(save_start),
    .dl_data(dl_data), .dl_valid(dl_valid), .dl_ready(dl_ready),
    .ul_data(ul_data), .ul_valid(ul_valid), .ul_ready(ul_ready),
    .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_data_out(hs_data_out),
    .hs_write_enable(hs_write_enable), .hs_access_write(hs_access_write),
    .pause_req(pause_req), .busy(busy), .done(done), .error(error)
  );

  always #5 clk_49m = ~clk_49m;

  logic [7:0]        ram [0:4095];
  logic [7:0]        p0, p1;
  logic              tb_we = 1'b0;
  logic [ADDR_W-1:0] tb_addr = '0;
  logic [7:0]        tb_data = '0;

  always @(posedge clk_49m) begin
    if (hs_write_enable)
      ram[hs_address] <= hs_data_in;
    else if (tb_we)
      ram[tb_addr] <= tb_data;
    p0 <= ram[hs_address];
    p1 <= p0;
  end
  assign hs_data_out = p1;

  int we_cnt = 0, done_cnt = 0, err_cnt = 0, pause_rise = 0, acc_cyc = 0, ul_acc = 0;
  logic pause_q = 1'b0;
  always @(negedge clk_49m) begin
    if (hs_write_enable) we_cnt++;
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (hs_access_write) acc_cyc++;
    if (ul_valid && ul_ready) ul_acc++;
    if (pause_req && !pause_q) pause_rise++;
    pause_q = pause_req;
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_49m);
    #1;
  endtask

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    tb_addr = a; tb_data = d; tb_we = 1'b1;
    step(1);
    tb_we = 1'b0;
  endtask

  task automatic frame();
    vblank = 1'b1;
    step(1);
    vblank = 1'b0;
  endtask

  task automatic wait_pause(input int max);
    for (int i = 0; i < max && !pause_req; i++) step(1);
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max && !done; i++) step(1);
  endtask

  task automatic wait_ul(input int max);
    for (int i = 0; i < max && !ul_valid; i++) step(1);
  endtask

  task automatic feed(input logic [7:0] b);
    dl_data  = b;
    dl_valid = 1'b1;
    for (int i = 0; i < 20 && !dl_ready; i++) step(1);
    chk("feed_ready", {31'd0, dl_ready}, 32'd1);
    step(1);
  endtask

  task automatic start_restore(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
    cfg_base = b; cfg_len = l; cfg_chk_addr = 12'h010; cfg_chk_val = 8'h5A;
    restore_start = 1'b1;
    step(1);
    restore_start = 1'b0;
  endtask

  function automatic logic [31:0] ctrl_vec();
    return {24'd0, dl_ready, ul_valid, hs_write_enable, hs_access_write,
            pause_req, busy, done, error};
  endfunction

  function automatic logic [31:0] data_vec();
    return {4'd0, ul_data, hs_data_in, hs_address};
  endfunction

  int we0, done0, err0, pr0, acc0, ula0, stall_bad;

  initial begin
    reset = 1'b0;
    step(2);
    chk("rst_ctrl", ctrl_vec(), 32'd0);
    chk("rst_data", data_vec(), 32'd0);
    reset = 1'b1;
    step(1);

    // restore, check byte matches on the first frame
    poke(12'h010, 8'h5A);
    for (int i = 0; i < 4; i++) poke(12'h100 + 12'(i), 8'h00);
    we0 = we_cnt; done0 = done_cnt; pr0 = pause_rise;
    start_restore(12'h100, 12'd4);
    chk("r1_busy", {31'd0, busy}, 32'd1);
    chk("r1_nopause_chk", {31'd0, pause_req}, 32'd0);
    step(3);
    frame();
    wait_pause(20);
    chk("r1_wrsync_pause", {31'd0, pause_req}, 32'd1);
    chk("r1_wrsync_noacc", {31'd0, hs_access_write}, 32'd0);
    frame();
    chk("r1_write_acc", {31'd0, hs_access_write}, 32'd1);
    feed(8'h11); feed(8'h22); feed(8'h33); feed(8'h44);
    dl_valid = 1'b0;
    wait_done(10);
    chk("r1_done", {31'd0, done}, 32'd1);
    chk("r1_done_pause", {31'd0, pause_req}, 32'd0);
    chk("r1_done_acc", {31'd0, hs_access_write}, 32'd0);
    step(1);
    chk("r1_idle", {31'd0, busy}, 32'd0);
    chk("r1_we_count", 32'(we_cnt - we0), 32'd4);
    chk("r1_done_count", 32'(done_cnt - done0), 32'd1);
    chk("r1_pause_rise", 32'(pause_rise - pr0), 32'd1);
    chk("r1_ram", {ram[12'h100], ram[12'h101], ram[12'h102], ram[12'h103]}, 32'h11223344);

    // check timeout after three non-matching frames
    poke(12'h020, 8'h00);
    we0 = we_cnt; err0 = err_cnt; pr0 = pause_rise;
    cfg_base = 12'h200; cfg_len = 12'd2; cfg_chk_addr = 12'h020; cfg_chk_val = 8'h77;
    restore_start = 1'b1;
    step(1);
    restore_start = 1'b0;
    frame(); step(8);
    frame(); step(8);
    chk("to_no_err_early", 32'(err_cnt - err0), 32'd0);
    chk("to_busy_early", {31'd0, busy}, 32'd1);
    frame(); step(8);
    chk("to_err", 32'(err_cnt - err0), 32'd1);
    chk("to_idle", {31'd0, busy}, 32'd0);
    chk("to_no_writes", 32'(we_cnt - we0), 32'd0);
    chk("to_no_pause", 32'(pause_rise - pr0), 32'd0);

    // save with wrap and backpressure on the second byte
    poke(12'hFFE, 8'hA1); poke(12'hFFF, 8'hA2); poke(12'h000, 8'hA3);
    acc0 = acc_cyc; done0 = done_cnt;
    cfg_base = 12'hFFE; cfg_len = 12'd3; ul_ready = 1'b0;
    save_start = 1'b1;
    step(1);
    save_start = 1'b0;
    wait_ul(30);
    chk("sv_b0", {24'd0, ul_data}, 32'h0000_00A1);
    ul_ready = 1'b1; step(1); ul_ready = 1'b0;
    wait_ul(30);
    chk("sv_b1", {24'd0, ul_data}, 32'h0000_00A2);
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!(ul_valid && ul_data == 8'hA2 && pause_req)) stall_bad++;
      step(1);
    end
    chk("sv_stall_stable", 32'(stall_bad), 32'd0);
    ul_ready = 1'b1; step(1); ul_ready = 1'b0;
    wait_ul(30);
    chk("sv_b2", {24'd0, ul_data}, 32'h0000_00A3);
    chk("sv_wrap_addr", {20'd0, hs_address}, 32'h0000_0000);
    ul_ready = 1'b1; step(1); ul_ready = 1'b0;
    wait_done(10);
    chk("sv_done", {31'd0, done}, 32'd1);
    chk("sv_no_access", 32'(acc_cyc - acc0), 32'd0);
    step(1);

    // simultaneous starts: save wins
    poke(12'h300, 8'h3C); poke(12'h301, 8'h3D);
    we0 = we_cnt; done0 = done_cnt; ula0 = ul_acc;
    cfg_base = 12'h300; cfg_len = 12'd2; cfg_chk_addr = 12'h010; cfg_chk_val = 8'h5A;
    save_start = 1'b1; restore_start = 1'b1;
    step(1);
    save_start = 1'b0; restore_start = 1'b0;
    chk("both_pause", {31'd0, pause_req}, 32'd1);
    ul_ready = 1'b1;
    wait_ul(30);
    chk("both_b0", {24'd0, ul_data}, 32'h0000_003C);
    wait_done(40);
    ul_ready = 1'b0;
    chk("both_done", {31'd0, done}, 32'd1);
    step(1);
    chk("both_no_writes", 32'(we_cnt - we0), 32'd0);
    chk("both_ul_count", 32'(ul_acc - ula0), 32'd2);

    // zero-length start
    pr0 = pause_rise;
    cfg_len = 12'd0;
    restore_start = 1'b1;
    step(1);
    restore_start = 1'b0;
    chk("zl_done", {31'd0, done}, 32'd1);
    chk("zl_busy", {31'd0, busy}, 32'd1);
    step(1);
    chk("zl_done_gone", {31'd0, done}, 32'd0);
    chk("zl_idle", {31'd0, busy}, 32'd0);
    chk("zl_no_pause", 32'(pause_rise - pr0), 32'd0);

    // reset during a write
    for (int i = 0; i < 4; i++) poke(12'h500 + 12'(i), 8'hEE);
    start_restore(12'h500, 12'd4);
    step(3);
    frame();
    wait_pause(20);
    frame();
    feed(8'h71); feed(8'h72);
    dl_valid = 1'b0;
    step(1);
    chk("mr_pre_pause", {31'd0, pause_req}, 32'd1);
    chk("mr_pre_acc", {31'd0, hs_access_write}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mr_ctrl_zero", ctrl_vec(), 32'd0);
    chk("mr_data_zero", data_vec(), 32'd0);
    chk("mr_ram", {ram[12'h500], ram[12'h501], ram[12'h502], ram[12'h503]}, 32'h7172EEEE);
    step(2);
    reset = 1'b1;
    step(1);
    start_restore(12'h500, 12'd2);
    step(3);
    frame();
    wait_pause(20);
    frame();
    feed(8'h61); feed(8'h62);
    dl_valid = 1'b0;
    wait_done(10);
    chk("mr2_done", {31'd0, done}, 32'd1);
    step(1);
    chk("mr2_ram", {ram[12'h500], ram[12'h501], ram[12'h502], ram[12'h503]}, 32'h6162EEEE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hiscore_xfer_engine.md
Name: hiscore_xfer_engine

Overview:
- Initiator/master for the core's high-score RAM port (hs_address / hs_data_in / hs_data_out / hs_write_enable / hs_access_write). The 005849 side is the responder.
- Restore: streams saved bytes into work RAM, but only after a check byte confirms the game has initialised its table.
- Save: reads a RAM window back out as a byte stream.
- Sits in the top level between the MiSTer hiscore loader and the PCB model. It drives the model's pause input while it is busy.

Parameters:
- ADDR_W, 12, width of hs_address.
- LEN_W, 12, width of the transfer length.
- RD_LAT, 2, clk_49m cycles from hs_address change to valid hs_data_out.
- CHK_TIMEOUT, 255, frames to wait for the check byte before giving up.

Ports:
- clk_49m  in  1  system clock, 49.152 MHz.
- reset  in  1  asynchronous, active-low; 0 = reset.
- vblank  in  1  core vertical blank; its rising edge is the frame tick.
- cfg_base  in  ADDR_W  first RAM address of the window.
- cfg_len  in  LEN_W  byte count; 0 = empty transfer.
- cfg_chk_addr  in  ADDR_W  address of the check byte.
- cfg_chk_val  in  8  expected value of the check byte.
- restore_start  in  1  one-cycle pulse; begins a restore.
- save_start  in  1  one-cycle pulse; begins a save.
- dl_data  in  8  restore byte.
- dl_valid  in  1  restore byte is valid.
- dl_ready  out  1  engine accepts the restore byte.
- ul_data  out  8  saved byte.
- ul_valid  out  1  saved byte is valid.
- ul_ready  in  1  consumer accepts the saved byte.
- hs_address  out  ADDR_W  RAM address to the core.
- hs_data_in  out  8  write data to the core.
- hs_data_out  in  8  read data from the core.
- hs_write_enable  out  1  one-cycle write strobe.
- hs_access_write  out  1  selects the core's write path.
- pause_req  out  1  halts the main CPU (ORed into pause).
- busy  out  1  engine is not idle.
- done  out  1  one-cycle pulse when a transfer completes.
- error  out  1  one-cycle pulse on check timeout.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs go to 0; state goes to IDLE.
  - Counters clear, the frame counter included.
  - If reset asserts mid-transfer, pause_req and hs_access_write drop immediately and the partial transfer is abandoned.
- Frame tick: a one-cycle pulse on the vblank 0->1 edge, using a registered previous value.
- Start arbitration:
  - Starts are sampled only in IDLE; while busy they are ignored.
  - If both starts pulse in the same cycle, save wins.
  - A start with cfg_len = 0 pulses done on the next cycle. No pause_req, no RAM access.
- The cfg_* inputs are latched at start and held for the whole transfer.
- Restore states:
  - CHK_WAIT: wait for a frame tick. If the frame count reaches CHK_TIMEOUT, pulse error and go to IDLE with no writes.
  - CHK_READ: drive hs_address = chk_addr and count RD_LAT cycles.
  - CHK_CMP: sample hs_data_out. A match goes to WR_SYNC; a mismatch increments the frame count and returns to CHK_WAIT.
  - WR_SYNC: assert pause_req, then wait for the next frame tick.
  - WRITE:
    - hs_access_write = 1 and dl_ready = 1.
    - On dl_valid & dl_ready: hs_data_in = dl_data, hs_address = base + idx, and hs_write_enable pulses for exactly one cycle.
    - idx increments after each accepted byte.
    - dl_ready drops for the cycle after each accept, giving at most 1 byte per 2 cycles.
  - WRITE exits after cfg_len bytes: go to DONE.
- Save states:
  - RD_ISSUE: assert pause_req and drive hs_address = base + idx, with hs_access_write = 0 throughout.
  - RD_WAIT: count RD_LAT cycles, then latch hs_data_out into ul_data.
  - RD_SEND: hold ul_valid = 1 with ul_data stable until ul_ready, then increment idx. Go to RD_ISSUE, or to DONE after cfg_len bytes.
  - Backpressure on ul_ready keeps the CPU paused; it is not a timeout.
- DONE: pulse done, deassert pause_req and hs_access_write in the same cycle, return to IDLE.
- Address arithmetic: base + idx is computed modulo 2^ADDR_W, so the window wraps at the top of the RAM.
- busy = (state != IDLE).
- dl_valid outside WRITE is ignored and dl_ready stays 0.

Decomposition:
- Package hiscore_pkg:
  - state enum: IDLE, CHK_WAIT, CHK_READ, CHK_CMP, WR_SYNC, WRITE, RD_ISSUE, RD_WAIT, RD_SEND, DONE.
  - Default widths.
- One sub-module, hs_frame_tick: the vblank edge detector plus the saturating frame counter, with clear and overflow flag.

Test Plan:
- Restore, check passes on the first frame:
  - Stimulus: RAM[0x010] = 0x5A; chk_addr = 0x010, chk_val = 0x5A, base = 0x100, len = 4; dl bytes 11, 22, 33, 44 offered back-to-back.
  - Response: after the next frame tick, RAM[0x100..0x103] = 11, 22, 33, 44. Exactly 4 hs_write_enable pulses, pause_req high from WR_SYNC to DONE, one done pulse.
- Check timeout:
  - Stimulus: check byte never matches; CHK_TIMEOUT = 3.
  - Response: error pulses after the 3rd frame tick; zero writes; pause_req never asserted.
- Save with backpressure:
  - Stimulus: RAM[0xFFE..0xFFF, 0x000] = A1, A2, A3; base = 0xFFE, len = 3; ul_ready held low for 10 cycles on the 2nd byte.
  - Response: output stream is A1, A2, A3 (wraps to 0x000). ul_data stays stable while stalled. hs_access_write stays 0 throughout.
- Both starts in the same cycle with len = 2:
  - Response: a save runs; no writes occur.
- Zero-length start:
  - Response: done on the next cycle, busy for 1 cycle, pause_req stays 0.
- Reset mid-write:
  - Stimulus: reset pulled low after 2 of 4 bytes have been written.
  - Response: all outputs are 0 within the same cycle; RAM[base+2..3] unchanged; a new restore after release works.
